// File: rtl/uop_pair_queue.sv
// Decode->rename uOP queue: compacts up to four valid decode lanes per cycle, in program order,
// into a circular buffer and presents the two oldest entries to rename.

module uop_pair_queue_chk #(
  parameter int DEPTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  input logic [$clog2(DEPTH):0]     count,
  input logic [$clog2(DEPTH)-1:0]   wr_ptr,
  input logic [$clog2(DEPTH)-1:0]   rd_ptr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] diff_s;

  assign diff_s = wr_ptr - rd_ptr;

  // Occupancy must never exceed capacity and must agree with the pointer distance
  always @(posedge clk) begin
    if (!rst) begin
      assert (count <= CNT_W'(DEPTH));
      assert ((count == {1'b0, diff_s}) ||
              ((count == CNT_W'(DEPTH)) && (diff_s == {PTR_W{1'b0}})));
    end
  end
endmodule

module uop_pair_queue #(
  parameter int UOP_W = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [3:0]               in_valid,
  input  logic [4*UOP_W-1:0]       in_uop,
  output logic                     in_ready,
  output logic                     pause_req,
  input  logic                     out_ready,
  output logic [1:0]               out_valid,
  output logic [UOP_W-1:0]         out_uop0,
  output logic [UOP_W-1:0]         out_uop1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RDY_LIM = CNT_W'(DEPTH - 4);

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  logic [UOP_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             push_s;
  logic [2:0]       nin_s;
  logic [1:0]       nout_s;
  logic [PTR_W-1:0] lane_addr_s [4];

  // Handshake, output view and per-lane compacted write addresses
  always_comb begin
    in_ready  = (count_r <= RDY_LIM);
    pause_req = !in_ready;
    push_s    = in_ready && (in_valid != 4'b0000);
    nin_s     = push_s ? popcnt4(in_valid) : 3'd0;
    out_valid = {(count_r >= CNT_W'(2)), (count_r != {CNT_W{1'b0}})};
    out_uop0  = mem_r[rd_ptr_r];
    out_uop1  = mem_r[rd_ptr_r + PTR_W'(1)];
    count     = count_r;
    if (!out_ready) begin
      nout_s = 2'd0;
    end else if (count_r >= CNT_W'(2)) begin
      nout_s = 2'd2;
    end else if (count_r == CNT_W'(1)) begin
      nout_s = 2'd1;
    end else begin
      nout_s = 2'd0;
    end
    // A lane lands after all lower-numbered valid lanes, so invalid lanes leave no holes
    for (int i = 0; i < 4; i++) begin
      lane_addr_s[i] = wr_ptr_r + PTR_W'(popcnt4(in_valid & ((4'b0001 << i) - 4'b0001)));
    end
  end

  // Pointer and occupancy update; reset or flush discards the whole cycle's traffic
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(nin_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(nout_s);
      count_r  <= count_r + CNT_W'(nin_s) - CNT_W'(nout_s);
    end
  end

  // Payload storage; written entries become visible one cycle later
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && !flush && push_s && in_valid[i]) begin
        mem_r[lane_addr_s[i]] <= in_uop[i*UOP_W +: UOP_W];
      end
    end
  end

  uop_pair_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .count  (count_r),
    .wr_ptr (wr_ptr_r),
    .rd_ptr (rd_ptr_r)
  );
endmodule

// File: tb/tb_uop_pair_queue.sv
// Self-checking bench for uop_pair_queue: directed scenarios with fixed expectations plus a
// randomized run compared against a queue-based reference model.
module tb_uop_pair_queue;
  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   in_valid;
  logic [255:0] in_uop;
  logic         in_ready;
  logic         pause_req;
  logic         out_ready;
  logic [1:0]   out_valid;
  logic [63:0]  out_uop0;
  logic [63:0]  out_uop1;
  logic [3:0]   count;

  int n_vec = 0;
  int n_err = 0;

  uop_pair_queue #(.UOP_W(64), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_uop    (in_uop),
    .in_ready  (in_ready),
    .pause_req (pause_req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_uop0  (out_uop0),
    .out_uop1  (out_uop1),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] d);
    in_valid = v;
    in_uop   = {d, c, b, a};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_lanes(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    tick(); tick();
    rst = 1'b0;
    n_vec++; if (out_valid !== 2'b00) begin $display("FAIL reset_out_valid: got %b want 00", out_valid); n_err++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", in_ready); n_err++; end
    n_vec++; if (pause_req !== 1'b0) begin $display("FAIL reset_pause_req: got %b want 0", pause_req); n_err++; end
    n_vec++; if (count !== 4'd0) begin $display("FAIL reset_count: got %0d want 0", count); n_err++; end
  endtask

  task automatic test_compact();
    out_ready = 1'b0;
    set_lanes(4'b1011, 64'hA, 64'hB, 64'hC, 64'hD);
    tick();
    set_lanes(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    n_vec++; if (count !== 4'd3) begin $display("FAIL compact_count: got %0d want 3", count); n_err++; end
    n_vec++; if (out_valid !== 2'b11) begin $display("FAIL compact_valid: got %b want 11", out_valid); n_err++; end
    n_vec++; if (out_uop0 !== 64'hA) begin $display("FAIL compact_out0: got %h want a", out_uop0); n_err++; end
    n_vec++; if (out_uop1 !== 64'hB) begin $display("FAIL compact_out1: got %h want b", out_uop1); n_err++; end
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_uop0 !== 64'hD) begin $display("FAIL compact_tail: got %h want d", out_uop0); n_err++; end
    n_vec++; if (out_valid !== 2'b01) begin $display("FAIL compact_single: got %b want 01", out_valid); n_err++; end
    tick();
    n_vec++; if (out_valid !== 2'b00) begin $display("FAIL compact_empty: got %b want 00", out_valid); n_err++; end
  endtask

  // Fill to capacity, hold a group while full, then drain; covers push+pop in the same cycle
  task automatic test_full();
    logic [63:0] exp0 [6];
    logic [3:0]  expc [6];
    exp0 = '{64'h12, 64'h14, 64'h16, 64'h20, 64'h22, 64'h0};
    expc = '{4'd6, 4'd4, 4'd6, 4'd4, 4'd2, 4'd0};
    out_ready = 1'b0;
    set_lanes(4'b1111, 64'h10, 64'h11, 64'h12, 64'h13);
    tick();
    set_lanes(4'b1111, 64'h14, 64'h15, 64'h16, 64'h17);
    tick();
    n_vec++; if (count !== 4'd8) begin $display("FAIL full_count: got %0d want 8", count); n_err++; end
    n_vec++; if (in_ready !== 1'b0) begin $display("FAIL full_in_ready: got %b want 0", in_ready); n_err++; end
    n_vec++; if (pause_req !== 1'b1) begin $display("FAIL full_pause: got %b want 1", pause_req); n_err++; end
    set_lanes(4'b1111, 64'h20, 64'h21, 64'h22, 64'h23);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (count !== 4'd8) begin $display("FAIL held_count[%0d]: got %0d want 8", k, count); n_err++; end
      n_vec++; if (out_uop0 !== 64'h10 || out_uop1 !== 64'h11) begin
        $display("FAIL held_data[%0d]: got %h %h want 10 11", k, out_uop0, out_uop1); n_err++; end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 2) set_lanes(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
      n_vec++; if (count !== expc[k]) begin $display("FAIL drain_count[%0d]: got %0d want %0d", k, count, expc[k]); n_err++; end
      if (expc[k] != 4'd0) begin
        n_vec++; if (out_uop0 !== exp0[k] || out_uop1 !== exp0[k] + 64'd1) begin
          $display("FAIL drain_data[%0d]: got %h %h want %h %h", k, out_uop0, out_uop1, exp0[k], exp0[k] + 64'd1); n_err++; end
      end else begin
        n_vec++; if (out_valid !== 2'b00) begin $display("FAIL drain_empty: got %b want 00", out_valid); n_err++; end
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_lanes(4'b1111, 64'h30, 64'h31, 64'h32, 64'h33);
    tick();
    set_lanes(4'b1000, 64'd0, 64'd0, 64'd0, 64'h34);
    tick();
    n_vec++; if (count !== 4'd5) begin $display("FAIL flush_pre_count: got %0d want 5", count); n_err++; end
    flush = 1'b1; out_ready = 1'b1;
    set_lanes(4'b1111, 64'h40, 64'h41, 64'h42, 64'h43);
    tick();
    flush = 1'b0;
    set_lanes(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    n_vec++; if (count !== 4'd0 || out_valid !== 2'b00) begin
      $display("FAIL flush_clear: got count=%0d valid=%b want 0 00", count, out_valid); n_err++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL flush_in_ready: got %b want 1", in_ready); n_err++; end
    tick();
    n_vec++; if (count !== 4'd0 || out_valid !== 2'b00) begin
      $display("FAIL flush_no_leak: got count=%0d valid=%b want 0 00", count, out_valid); n_err++; end
    set_lanes(4'b1111, 64'h50, 64'h51, 64'h52, 64'h53);
    tick();
    rst = 1'b1;
    set_lanes(4'b1111, 64'h60, 64'h61, 64'h62, 64'h63);
    tick();
    rst = 1'b0;
    set_lanes(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    n_vec++; if (count !== 4'd0 || out_valid !== 2'b00) begin
      $display("FAIL rst_mid_clear: got count=%0d valid=%b want 0 00", count, out_valid); n_err++; end
    tick();
    n_vec++; if (count !== 4'd0 || out_valid !== 2'b00) begin
      $display("FAIL rst_mid_no_leak: got count=%0d valid=%b want 0 00", count, out_valid); n_err++; end
  endtask

  // Reference: an ordered list of entries; accept a group whole when at most 4 are held
  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] lane_v [4];
    logic [31:0] tag;
    int          npop;
    bit          accept;
    tag = 32'd1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int l = 0; l < 4; l++) begin
        lane_v[l] = {$urandom(), tag};
        tag++;
      end
      set_lanes(4'($urandom_range(0, 15)), lane_v[0], lane_v[1], lane_v[2], lane_v[3]);
      out_ready = ($urandom_range(0, 9) < 7);
      n_vec++; if (count !== 4'(q.size())) begin $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, q.size()); n_err++; end
      n_vec++; if (in_ready !== (q.size() <= 4)) begin $display("FAIL rnd_in_ready@%0d: got %b count %0d", cyc, in_ready, q.size()); n_err++; end
      n_vec++; if (pause_req !== (q.size() > 4)) begin $display("FAIL rnd_pause@%0d: got %b count %0d", cyc, pause_req, q.size()); n_err++; end
      n_vec++; if (out_valid !== {q.size() >= 2, q.size() >= 1}) begin
        $display("FAIL rnd_valid@%0d: got %b size %0d", cyc, out_valid, q.size()); n_err++; end
      if (q.size() >= 1) begin
        n_vec++; if (out_uop0 !== q[0]) begin $display("FAIL rnd_out0@%0d: got %h want %h", cyc, out_uop0, q[0]); n_err++; end
      end
      if (q.size() >= 2) begin
        n_vec++; if (out_uop1 !== q[1]) begin $display("FAIL rnd_out1@%0d: got %h want %h", cyc, out_uop1, q[1]); n_err++; end
      end
      accept = (q.size() <= 4);
      npop   = out_ready ? ((q.size() >= 2) ? 2 : q.size()) : 0;
      tick();
      for (int p = 0; p < npop; p++) void'(q.pop_front());
      if (accept) begin
        for (int l = 0; l < 4; l++) if (in_valid[l]) q.push_back(lane_v[l]);
      end
    end
    set_lanes(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      n_vec++; if (out_uop0 !== q[0]) begin $display("FAIL rnd_drain@%0d: got %h want %h", k, out_uop0, q[0]); n_err++; end
      npop = (q.size() >= 2) ? 2 : q.size();
      tick();
      for (int p = 0; p < npop; p++) void'(q.pop_front());
    end
    n_vec++; if (count !== 4'd0) begin $display("FAIL rnd_final_count: got %0d want 0", count); n_err++; end
  endtask

  initial begin
    test_reset();
    test_compact();
    test_full();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
